// File: rtl/rib_slave_ram.sv
// Word-organised RAM slave for the core's RIB data port.
// Inserts WAIT_CYCLES stall cycles per access via hold_flag_o; zero-wait is purely combinational.
module rib_slave_ram #(
   parameter int unsigned ADDR_BITS   = 12,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        hold_flag_o,
   output logic        err_o,
   output logic        busy_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;

   logic [31:0]          mem [DEPTH];
   logic [ADDR_BITS-1:0] idx;
   logic                 in_range;
   logic                 mem_we;
   logic [ADDR_BITS-1:0] mem_widx;
   logic [31:0]          mem_wdata;
   logic                 unused_addr;

   assign idx         = addr_i[ADDR_BITS+1:2];
   assign in_range    = (addr_i[31:ADDR_BITS+2] == '0);
   assign unused_addr = ^addr_i[1:0];

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_widx] <= mem_wdata;
      end
   end

   generate
      if (WAIT_CYCLES == 0) begin : g_zero_wait
         logic err_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               err_q <= 1'b0;
            end else begin
               err_q <= req_i & ~in_range;
            end
         end

         assign mem_we      = rst & req_i & we_i & in_range;
         assign mem_widx    = idx;
         assign mem_wdata   = data_i;
         assign data_o      = (rst & req_i & ~we_i & in_range) ? mem[idx] : 32'h0;
         assign hold_flag_o = 1'b0;
         assign busy_o      = 1'b0;
         assign err_o       = err_q;
      end else begin : g_wait
         typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

         localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

         state_e               state_q;
         logic [3:0]           cnt_q;
         logic [ADDR_BITS-1:0] idx_q;
         logic                 in_range_q;
         logic                 we_q;
         logic                 err_q;
         logic [31:0]          wdata_q;
         logic [31:0]          rdata_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_q    <= StIdle;
               cnt_q      <= 4'd0;
               idx_q      <= '0;
               in_range_q <= 1'b0;
               we_q       <= 1'b0;
               err_q      <= 1'b0;
               wdata_q    <= 32'h0;
               rdata_q    <= 32'h0;
            end else begin
               err_q <= 1'b0;
               unique case (state_q)
                  StIdle: begin
                     if (req_i) begin
                        idx_q      <= idx;
                        in_range_q <= in_range;
                        we_q       <= we_i;
                        wdata_q    <= data_i;
                        cnt_q      <= 4'd1;
                        if (WAIT_CYCLES == 1) begin
                           state_q <= StAck;
                           err_q   <= ~in_range;
                           rdata_q <= (we_i | ~in_range) ? 32'h0 : mem[idx];
                        end else begin
                           state_q <= StWait;
                        end
                     end
                  end
                  StWait: begin
                     // Initiator dropping req (flush) abandons the access silently.
                     if (!req_i) begin
                        state_q <= StIdle;
                     end else begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == LastCnt) begin
                           state_q <= StAck;
                           err_q   <= ~in_range_q;
                           rdata_q <= (we_q | ~in_range_q) ? 32'h0 : mem[idx_q];
                        end
                     end
                  end
                  StAck: begin
                     state_q <= StIdle;
                  end
                  default: begin
                     state_q <= StIdle;
                  end
               endcase
            end
         end

         assign mem_we      = (state_q == StAck) & we_q & in_range_q;
         assign mem_widx    = idx_q;
         assign mem_wdata   = wdata_q;
         assign data_o      = (state_q == StAck) ? rdata_q : 32'h0;
         assign hold_flag_o = rst & req_i & (state_q != StAck);
         assign busy_o      = (state_q != StIdle);
         assign err_o       = err_q;
      end
   endgenerate

endmodule

// File: tb/tb_rib_slave_ram.sv
// Directed bench for rib_slave_ram: a 2-wait-state instance and a zero-wait instance.
module tb_rib_slave_ram;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req2, we2, hold2, err2, busy2;
   logic [31:0] addr2, wd2, rd2;
   logic        req0, we0, hold0, err0, busy0;
   logic [31:0] addr0, wd0, rd0;

   int n_checks = 0;
   int n_fail   = 0;

   rib_slave_ram #(.ADDR_BITS(12), .WAIT_CYCLES(2)) dut_w2 (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req2),
      .we_i        (we2),
      .addr_i      (addr2),
      .data_i      (wd2),
      .data_o      (rd2),
      .hold_flag_o (hold2),
      .err_o       (err2),
      .busy_o      (busy2)
   );

   rib_slave_ram #(.ADDR_BITS(12), .WAIT_CYCLES(0)) dut_w0 (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req0),
      .we_i        (we0),
      .addr_i      (addr0),
      .data_i      (wd0),
      .data_o      (rd0),
      .hold_flag_o (hold0),
      .err_o       (err0),
      .busy_o      (busy0)
   );

   // Request must not change while the slave is stalling the initiator.
   logic        prev_hold = 1'b0;
   logic [64:0] prev_req  = '0;
   always @(negedge clk) begin
      if (prev_hold && req2) begin
         n_checks++;
         if ({we2, addr2, wd2} !== prev_req) begin
            n_fail++;
            $display("FAIL req_stability: got %h want %h", {we2, addr2, wd2}, prev_req);
         end
      end
      prev_hold <= hold2;
      prev_req  <= {we2, addr2, wd2};
   end

   task automatic drive2(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      req2 = r; we2 = w; addr2 = a; wd2 = d;
   endtask

   task automatic drive0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      req0 = r; we0 = w; addr0 = a; wd0 = d;
   endtask

   // One full access on the 2-wait instance with req held throughout; leaves req asserted.
   task automatic access2(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input logic exp_err, input string name);
      drive2(1'b1, w, a, d);
      @(negedge clk);
      n_checks++;
      if (hold2 !== 1'b1 || busy2 !== 1'b0 || rd2 !== 32'h0) begin
         n_fail++;
         $display("FAIL %s_c0: hold=%b busy=%b data=%h want hold=1 busy=0 data=0",
                  name, hold2, busy2, rd2);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (hold2 !== 1'b1 || busy2 !== 1'b1 || rd2 !== 32'h0 || err2 !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_c1: hold=%b busy=%b data=%h err=%b want hold=1 busy=1 data=0 err=0",
                  name, hold2, busy2, rd2, err2);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (hold2 !== 1'b0 || busy2 !== 1'b1 || rd2 !== exp || err2 !== exp_err) begin
         n_fail++;
         $display("FAIL %s_ack: hold=%b busy=%b data=%h err=%b want hold=0 busy=1 data=%h err=%b",
                  name, hold2, busy2, rd2, err2, exp, exp_err);
      end
   endtask

   task automatic idle2(input string name);
      drive2(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      n_checks++;
      if (hold2 !== 1'b0 || busy2 !== 1'b0 || rd2 !== 32'h0 || err2 !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: hold=%b busy=%b data=%h err=%b want all 0",
                  name, hold2, busy2, rd2, err2);
      end
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (hold2 !== 1'b0 || busy2 !== 1'b0 || rd2 !== 32'h0 || err2 !== 1'b0 ||
          hold0 !== 1'b0 || busy0 !== 1'b0 || rd0 !== 32'h0 || err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: w2 %b%b%h%b w0 %b%b%h%b want all 0",
                  hold2, busy2, rd2, err2, hold0, busy0, rd0, err0);
      end
      @(negedge clk);
      rst = 1'b1;
      idle2("reset_idle_w2");
      n_checks++;
      if (hold0 !== 1'b0 || busy0 !== 1'b0 || rd0 !== 32'h0 || err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_w0: hold=%b busy=%b data=%h err=%b want all 0",
                  hold0, busy0, rd0, err0);
      end
   endtask

   task automatic test_write_read();
      access2(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, "wr10");
      idle2("wr10_after");
      access2(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd10");
      idle2("rd10_after");
   endtask

   task automatic test_back_to_back();
      access2(1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0, 1'b0, "b2b_wr0");
      access2(1'b1, 32'h0000_0004, 32'h2222_2222, 32'h0, 1'b0, "b2b_wr4");
      access2(1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111, 1'b0, "b2b_rd0");
      access2(1'b0, 32'h0000_0004, 32'h0, 32'h2222_2222, 1'b0, "b2b_rd4");
      idle2("b2b_after");
   endtask

   task automatic test_out_of_range();
      access2(1'b0, 32'h0001_0000, 32'h0, 32'h0, 1'b1, "oor_rd");
      idle2("oor_rd_after");
      // 0x0001_0000 aliases word 0 in the low bits, so a leaked write would clobber it.
      access2(1'b1, 32'h0001_0000, 32'h0000_1234, 32'h0, 1'b1, "oor_wr");
      idle2("oor_wr_after");
      access2(1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111, 1'b0, "oor_rd0");
      idle2("oor_rd0_after");
   endtask

   task automatic test_abort();
      access2(1'b1, 32'h0000_0008, 32'h3333_3333, 32'h0, 1'b0, "abort_pre");
      idle2("abort_pre_after");
      drive2(1'b1, 1'b1, 32'h0000_0008, 32'h4444_4444);
      @(negedge clk);
      n_checks++;
      if (hold2 !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_c0: hold=%b want 1", hold2);
      end
      drive2(1'b0, 1'b1, 32'h0000_0008, 32'h4444_4444);
      @(negedge clk);
      n_checks++;
      if (hold2 !== 1'b0 || busy2 !== 1'b1 || rd2 !== 32'h0 || err2 !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_wait: hold=%b busy=%b data=%h err=%b want hold=0 busy=1 data=0 err=0",
                  hold2, busy2, rd2, err2);
      end
      idle2("abort_idle");
      access2(1'b0, 32'h0000_0008, 32'h0, 32'h3333_3333, 1'b0, "abort_rd8");
      idle2("abort_rd8_after");
   endtask

   task automatic test_reset_mid_wait();
      drive2(1'b1, 1'b1, 32'h0000_0008, 32'h5555_5555);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (hold2 !== 1'b1 || busy2 !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_wait: hold=%b busy=%b want 1 1", hold2, busy2);
      end
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (hold2 !== 1'b0 || busy2 !== 1'b0 || rd2 !== 32'h0) begin
         n_fail++;
         $display("FAIL rstmid_async: hold=%b busy=%b data=%h want all 0", hold2, busy2, rd2);
      end
      drive2(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      idle2("rstmid_idle");
      access2(1'b0, 32'h0000_0008, 32'h0, 32'h3333_3333, 1'b0, "rstmid_rd8");
      idle2("rstmid_rd8_after");
   endtask

   task automatic test_zero_wait();
      drive0(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
      @(negedge clk);
      n_checks++;
      if (hold0 !== 1'b0 || rd0 !== 32'h0) begin
         n_fail++;
         $display("FAIL zw_wr: hold=%b data=%h want 0 0", hold0, rd0);
      end
      drive0(1'b1, 1'b0, 32'h0000_0020, 32'h0);
      @(negedge clk);
      n_checks++;
      if (hold0 !== 1'b0 || rd0 !== 32'hA5A5_A5A5 || err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL zw_rd: hold=%b data=%h err=%b want 0 a5a5a5a5 0", hold0, rd0, err0);
      end
      drive0(1'b1, 1'b0, 32'h0001_0000, 32'h0);
      @(negedge clk);
      n_checks++;
      if (hold0 !== 1'b0 || rd0 !== 32'h0 || err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL zw_oor_rd: hold=%b data=%h err=%b want 0 0 0", hold0, rd0, err0);
      end
      drive0(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      n_checks++;
      if (hold0 !== 1'b0 || rd0 !== 32'h0 || err0 !== 1'b1) begin
         n_fail++;
         $display("FAIL zw_oor_err: hold=%b data=%h err=%b want 0 0 1", hold0, rd0, err0);
      end
      drive0(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      n_checks++;
      if (err0 !== 1'b0 || busy0 !== 1'b0) begin
         n_fail++;
         $display("FAIL zw_err_clear: err=%b busy=%b want 0 0", err0, busy0);
      end
   endtask

   initial begin
      rst = 1'b0;
      req2 = 1'b0; we2 = 1'b0; addr2 = 32'h0; wd2 = 32'h0;
      req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wd0 = 32'h0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_out_of_range();
      test_abort();
      test_reset_mid_wait();
      test_zero_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rib_slave_ram.md
Name: rib_slave_ram

Overview:
- Word-organised RAM that answers the core's RIB data port: req/we/addr/wdata in, rdata out.
- Inserts a configurable number of wait states by raising a hold flag, which the top level feeds to the core's rib_hold_flag_i.
- Models slow peripherals/memories, so the pipeline-stall path can be exercised against a real responder.

Parameters:
- ADDR_BITS, 12, word-index width; DEPTH = 2**ADDR_BITS words of 32 bits.
- WAIT_CYCLES, 2, stall cycles inserted per access (0..15); 0 = zero-wait.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  1  access request from the core's ex stage (combinational on the initiator side).
- we_i  in  1  1 = write, 0 = read; valid with req_i.
- addr_i  in  32  byte address; word index = addr_i[ADDR_BITS+1:2]; bits [1:0] ignored.
- data_i  in  32  write data.
- data_o  out  32  read data, valid only in the acknowledge cycle.
- hold_flag_o  out  1  stall request to the core; combinational from req_i and state.
- err_o  out  1  one-cycle pulse: the access just acknowledged was out of range.
- busy_o  out  1  1 while an access is in progress (state != IDLE).

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, cnt=0, rdata_q=0, err_o=0.
  - hold_flag_o=0, busy_o=0, data_o=0.
  - RAM contents are not reset.
- In range: addr_i[31:ADDR_BITS+2]==0. Out-of-range reads return 0, writes are dropped, and err_o=1 in the acknowledge cycle.
- WAIT_CYCLES==0:
  - No FSM; hold_flag_o is tied to 0.
  - data_o = req_i&~we_i ? mem[idx] (combinational) : 0.
  - Write commits at the clock edge where req_i&we_i=1.
  - err_o is registered: it is the out-of-range flag of the previous cycle's access.
- WAIT_CYCLES>0, states IDLE, WAIT, ACK:
  - IDLE:
    - hold_flag_o = req_i.
    - On req_i=1: latch addr/we/data into request registers, cnt<=1, go to WAIT (or to ACK if WAIT_CYCLES==1).
  - WAIT:
    - hold_flag_o = req_i.
    - cnt<=cnt+1; when cnt==WAIT_CYCLES-1, go to ACK.
    - On the WAIT->ACK edge, capture rdata_q<=mem[latched idx] (or 0 if out of range).
  - ACK:
    - hold_flag_o=0, data_o=rdata_q (0 for writes).
    - Latched write commits at the ACK clock edge; err_o reflects the latched range check.
    - Next state is always IDLE.
  - Net latency: with req_i held from cycle 0, hold_flag_o is high in cycles 0..WAIT_CYCLES-1, and cycle WAIT_CYCLES is the ACK (core advances).
  - Back-to-back: the cycle after ACK is IDLE. A new req_i there starts a fresh access, so the next stall begins immediately.
- Abort: req_i=0 in WAIT returns to IDLE next cycle with no write and no err_o. This covers the core deasserting req on a jump/interrupt flush.
- Request stability: addr_i/we_i/data_i must stay constant while hold_flag_o=1. The block uses latched copies; the bench asserts stability.
- data_o=0 in every cycle that is not an ACK (or a zero-wait read).
- Async reset mid-access: returns to IDLE at once, the pending write is lost, and hold_flag_o drops combinationally.

Test Plan:
- Reset, then idle with req_i=0 -> hold_flag_o=0, data_o=0, busy_o=0, err_o=0.
- WAIT_CYCLES=2: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 (req held) -> hold high for 2 cycles each; ACK cycle data_o=0xDEADBEEF; word at idx 4 updated.
- Back-to-back reads of 0x0 and 0x4 with req_i continuous -> pattern hold=1,1,0,1,1,0; data_o correct in each ACK.
- Read 0x0001_0000 with ADDR_BITS=12 -> data_o=0 and err_o=1 in the ACK. Write 0x1234 there -> RAM unchanged and err_o=1.
- Write to 0x8 with req_i dropped after 1 WAIT cycle -> state IDLE next cycle; later read of 0x8 returns the old value; err_o=0.
- WAIT_CYCLES=0: write 0xA5A5A5A5 to 0x20, then read 0x20 -> hold_flag_o never 1; same-cycle data_o=0xA5A5A5A5. Separately, rst pulsed low mid-WAIT -> hold_flag_o=0 at once and the write is not committed.
